// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status encoding and word type.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of icache, dcache and RAM signals seen by the memory arbiter.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    // icache side
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    // dcache side
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // Arbiter view
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Cache/RAM environment view
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: dcache priority with a starvation guard for icache.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)(
    input  logic          CLK,
    input  logic          RST,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISERV,
        DSERV
    } arb_state_t;

    arb_state_t    state;
    logic [CW-1:0] starve_cnt;

    logic d_req;
    logic ram_done;
    logic i_starved;
    logic cnt_sat;

    // Request and completion qualifiers shared by FSM and output mux
    always_comb begin
        d_req     = bus.dREN | bus.dWEN;
        ram_done  = (bus.ramstate == ACCESS);
        cnt_sat   = (starve_cnt == CW'(STARVE_LIMIT));
        i_starved = cnt_sat & bus.iREN;
    end

    // Arbitration FSM and starvation counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !i_starved) begin
                        state <= DSERV;
                        if (bus.iREN && !cnt_sat)
                            starve_cnt <= starve_cnt + CW'(1);
                    end else if (bus.iREN) begin
                        state      <= ISERV;
                        starve_cnt <= '0;
                    end
                end
                ISERV: begin
                    if (!bus.iREN || ram_done)
                        state <= IDLE;
                end
                DSERV: begin
                    if (!d_req || ram_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational RAM request mux, load steering and stall generation
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iload    = '0;
        bus.dload    = '0;
        case (state)
            ISERV: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                bus.iload   = bus.ramload;
            end
            DSERV: begin
                // a write takes precedence when both enables are raised
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dload    = bus.ramload;
            end
            default: ;
        endcase
        bus.iwait = bus.iREN & ~((state == ISERV) & ram_done);
        bus.dwait = d_req & ~((state == DSERV) & ram_done);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LIMIT = 4;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the RAM (0 none, 1 icache, 2 dcache) and starvation count
    int owner;
    int cnt;

    // Observations captured during the last step
    logic        obs_ren, obs_wen, obs_iwait, obs_dwait;
    logic [31:0] obs_addr, obs_iload, obs_dload;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    task automatic step();
        logic        dreq, acc;
        logic        e_ren, e_wen, e_iwait, e_dwait;
        logic [31:0] e_addr, e_store, e_iload, e_dload;
        @(negedge CLK);
        dreq    = bus.dREN | bus.dWEN;
        acc     = (bus.ramstate == ACCESS);
        e_ren   = 1'b0;
        e_wen   = 1'b0;
        e_addr  = 32'h0;
        e_store = 32'h0;
        e_iload = 32'h0;
        e_dload = 32'h0;
        if (owner == 1) begin
            e_ren   = 1'b1;
            e_addr  = bus.iaddr;
            e_iload = bus.ramload;
        end else if (owner == 2) begin
            e_wen   = bus.dWEN;
            e_ren   = bus.dREN && !bus.dWEN;
            e_addr  = bus.daddr;
            e_store = bus.dstore;
            e_dload = bus.ramload;
        end
        e_iwait = bus.iREN && !(owner == 1 && acc);
        e_dwait = dreq && !(owner == 2 && acc);

        chk("ramREN",   32'(bus.ramREN),   32'(e_ren));
        chk("ramWEN",   32'(bus.ramWEN),   32'(e_wen));
        chk("ramaddr",  bus.ramaddr,       e_addr);
        chk("ramstore", bus.ramstore,      e_store);
        chk("iload",    bus.iload,         e_iload);
        chk("dload",    bus.dload,         e_dload);
        chk("iwait",    32'(bus.iwait),    32'(e_iwait));
        chk("dwait",    32'(bus.dwait),    32'(e_dwait));
        chk("starve",   32'(dut.starve_cnt), 32'(cnt));

        obs_ren   = bus.ramREN;
        obs_wen   = bus.ramWEN;
        obs_addr  = bus.ramaddr;
        obs_iload = bus.iload;
        obs_dload = bus.dload;
        obs_iwait = bus.iwait;
        obs_dwait = bus.dwait;

        if (RST) begin
            owner = 0;
            cnt   = 0;
        end else if (owner == 0) begin
            if (bus.iREN && (!dreq || cnt == LIMIT)) begin
                owner = 1;
                cnt   = 0;
            end else if (dreq) begin
                owner = 2;
                if (bus.iREN) cnt = (cnt + 1 > LIMIT) ? LIMIT : cnt + 1;
            end
        end else if (owner == 1) begin
            if (!bus.iREN || acc) owner = 0;
        end else begin
            if (!dreq || acc) owner = 0;
        end

        @(posedge CLK);
        #1;
    endtask

    initial begin
        int dseen;
        int iseen;

        RST          = 1'b1;
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'h0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'h0;
        bus.dstore   = 32'h0;
        bus.ramload  = 32'h0;
        bus.ramstate = FREE;
        @(posedge CLK);
        #1;
        owner = 0;
        cnt   = 0;

        // Reset state with garbage on the inputs
        bus.ramload = 32'hFFFF_FFFF;
        bus.daddr   = 32'hABCD_0000;
        step();
        RST = 1'b0;
        bus.ramload = 32'h0;
        step();
        chk("idle_ren", 32'(obs_ren), 32'h0);

        // Scenario 1: icache read, ACCESS on second ISERV cycle
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h100;
        bus.ramload  = 32'hDEADBEEF;
        bus.ramstate = BUSY;
        step();
        step();
        chk("s1_grant_addr", obs_addr, 32'h100);
        bus.ramstate = ACCESS;
        step();
        chk("s1_iwait", 32'(obs_iwait), 32'h0);
        chk("s1_iload", obs_iload, 32'hDEADBEEF);
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        step();
        chk("s1_idle_ren", 32'(obs_ren), 32'h0);

        // Scenario 2: simultaneous icache read and dcache write
        bus.iREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h200;
        bus.dstore   = 32'h12345678;
        bus.ramstate = ACCESS;
        step();
        step();
        chk("s2_dwen",  32'(obs_wen), 32'h1);
        chk("s2_daddr", obs_addr, 32'h200);
        bus.dWEN = 1'b0;
        step();
        chk("s2_bubble", 32'(obs_ren | obs_wen), 32'h0);
        step();
        chk("s2_iserv_addr", obs_addr, 32'h100);
        chk("s2_iserv_ren",  32'(obs_ren), 32'h1);
        bus.iREN = 1'b0;
        step();

        // Scenario 3: continuous dcache traffic starving icache
        bus.iREN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.iaddr    = 32'h100;
        bus.daddr    = 32'h300;
        bus.ramstate = ACCESS;
        dseen = 0;
        iseen = 0;
        for (int i = 0; i < 40 && iseen == 0; i++) begin
            step();
            if (obs_ren && obs_addr == 32'h300) dseen++;
            if (obs_ren && obs_addr == 32'h100) iseen = 1;
        end
        chk("s3_iserv_reached", 32'(iseen), 32'h1);
        chk("s3_dgrants", 32'(dseen), 32'(LIMIT));
        chk("s3_cnt_clear", 32'(dut.starve_cnt), 32'h0);
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        step();

        // Scenario 4: ERROR retried three times, then ACCESS
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h440;
        bus.ramload  = 32'h0BAD_F00D;
        bus.ramstate = ERROR;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s4_ren",   32'(obs_ren), 32'h1);
            chk("s4_addr",  obs_addr, 32'h440);
            chk("s4_dwait", 32'(obs_dwait), 32'h1);
        end
        bus.ramstate = ACCESS;
        step();
        chk("s4_done",  32'(obs_dwait), 32'h0);
        chk("s4_dload", obs_dload, 32'h0BAD_F00D);
        bus.dREN     = 1'b0;
        bus.ramstate = FREE;
        step();

        // Scenario 5: reset during a BUSY icache access
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h500;
        bus.ramstate = BUSY;
        step();
        step();
        chk("s5_iserv", 32'(obs_ren), 32'h1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        bus.ramstate = ACCESS;
        step();
        chk("s5_ren",   32'(obs_ren), 32'h0);
        chk("s5_nopulse", 32'(obs_iwait), 32'h1);
        chk("s5_iload", obs_iload, 32'h0);
        bus.iREN     = 1'b0;
        bus.ramstate = FREE;
        step();
        step();

        // Scenario 6: dcache drops its request mid-access
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h600;
        bus.ramstate = BUSY;
        step();
        step();
        chk("s6_dserv", 32'(obs_ren), 32'h1);
        bus.dREN = 1'b0;
        step();
        chk("s6_abort_ren",   32'(obs_ren), 32'h0);
        chk("s6_abort_dwait", 32'(obs_dwait), 32'h0);
        step();
        chk("s6_idle_ren", 32'(obs_ren), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            RST          = ($urandom_range(0, 49) == 0);
            bus.iREN     = ($urandom_range(0, 3) != 0);
            bus.dREN     = ($urandom_range(0, 1) == 1);
            bus.dWEN     = ($urandom_range(0, 3) == 0);
            bus.iaddr    = $urandom;
            bus.daddr    = $urandom;
            bus.dstore   = $urandom;
            bus.ramload  = $urandom;
            bus.ramstate = ramstate_t'($urandom_range(0, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive dcache grants while an icache request is pending.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 iREN  in  1  icache read request.
REQ-006 iaddr  in  32  icache word address.
REQ-007 iwait  out  1  icache stall; low marks completion.
REQ-008 iload  out  32  icache read data.
REQ-009 dREN  in  1  dcache read request.
REQ-010 dWEN  in  1  dcache write request.
REQ-011 daddr  in  32  dcache word address.
REQ-012 dstore  in  32  dcache write data.
REQ-013 dwait  out  1  dcache stall; low marks completion.
REQ-014 dload  out  32  dcache read data.
REQ-015 ramREN  out  1  RAM read enable.
REQ-016 ramWEN  out  1  RAM write enable.
REQ-017 ramaddr  out  32  RAM address.
REQ-018 ramstore  out  32  RAM write data.
REQ-019 ramload  in  32  RAM read data.
REQ-020 ramstate  in  2  RAM status, one of FREE, BUSY, ACCESS, ERROR.

Function
REQ-021 The FSM SHALL have three states: IDLE, ISERV and DSERV.
REQ-022 IDLE SHALL drive ramREN=0, ramWEN=0, ramaddr=0 and ramstore=0.
REQ-023 In IDLE, if any request is pending, the FSM SHALL move to ISERV or DSERV on the next edge, giving a 1-cycle grant latency.
REQ-024 Arbitration SHALL favour the dcache (dREN|dWEN) over iREN, unless the starvation counter equals STARVE_LIMIT and iREN=1, in which case ISERV SHALL win.
REQ-025 The starvation counter SHALL increment, saturating at STARVE_LIMIT, on each DSERV grant made while iREN=1.
REQ-026 The starvation counter SHALL clear on every ISERV grant, and SHALL hold otherwise.
REQ-027 The starvation counter width SHALL be $clog2(STARVE_LIMIT+1).
REQ-028 In ISERV, outputs SHALL be combinational: ramREN=1, ramWEN=0, ramaddr=iaddr, iload=ramload.
REQ-029 In DSERV, outputs SHALL be combinational: ramaddr=daddr, ramstore=dstore, dload=ramload.
REQ-030 In DSERV, if dWEN=1 the block SHALL drive ramWEN=1 and ramREN=0, even when dREN=1 (write wins).
REQ-031 In DSERV, if dWEN=0 and dREN=1 the block SHALL drive ramREN=1 and ramWEN=0.
REQ-032 Completion is a cycle in xSERV with ramstate=ACCESS.
REQ-033 On completion, the owner's wait SHALL be 0 in that same cycle, and the FSM SHALL return to IDLE on the next edge (one mandatory bubble).
REQ-034 iwait SHALL equal iREN AND NOT (ISERV AND ramstate=ACCESS); dwait SHALL be defined the same way over (dREN|dWEN) and DSERV.
REQ-035 iload and dload SHALL be 0 whenever their owner is not in service.
REQ-036 ramstate FREE, BUSY or ERROR SHALL hold the current state, and the RAM request SHALL be reissued unchanged (ERROR is a retry, never a completion).
REQ-037 If the owner deasserts its request while in xSERV, the FSM SHALL abort to IDLE on the next edge, with RAM enables low in the following cycle.
REQ-038 Requests arriving while another requester is in service SHALL wait, and SHALL be arbitrated only from IDLE.
REQ-039 With no requests pending, the FSM SHALL stay in IDLE and both wait outputs SHALL be 0.

Reset
REQ-040 When RST=1 at a rising edge, the state SHALL become IDLE and the starvation counter 0, regardless of any in-flight access.
REQ-041 In the cycle after reset, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0 and dload=0.
REQ-042 An access interrupted by reset SHALL NOT be resumed; requesters re-arbitrate from IDLE.

Structure
REQ-043 The ramstate enum SHALL live in cpu_types_pkg.
REQ-044 The arbiter FSM state enum SHALL be local to mem_arbiter.
REQ-045 No sub-module is required; the FSM, starvation counter and output mux SHALL reside in one module.

Verification
REQ-046 Scenario 1: iREN=1, iaddr=0x100, ramstate ACCESS on the 2nd ISERV cycle, ramload=0xDEADBEEF -> ISERV one cycle after request, iwait=0 with iload=0xDEADBEEF in the ACCESS cycle, then IDLE.
REQ-047 Scenario 2: iREN and dWEN both asserted at cycle 0, daddr=0x200, dstore=0x12345678 -> DSERV granted first with ramWEN=1 and ramaddr=0x200, then IDLE, then ISERV.
REQ-048 Scenario 3: iREN held high with dREN re-asserted continuously, STARVE_LIMIT=4 -> exactly 4 DSERV grants, then ISERV, then the counter reads 0.
REQ-049 Scenario 4: in DSERV, ramstate=ERROR for 3 cycles, then ACCESS -> ram signals stable and dwait=1 for 3 cycles, completion on the 4th.
REQ-050 Scenario 5: RST=1 during ISERV with ramstate=BUSY -> IDLE next cycle, ramREN=0, counter 0, and no completion pulse.
REQ-051 Scenario 6: dREN dropped mid-DSERV while ramstate=BUSY -> IDLE next cycle, ramREN=0, dwait=0.
